key_history_display: RTL
========================

// Module: key_history_display
// PURPOSE
//  Consumes the debounced keypad key (4-bit hex value plus valid level) from the scanner stage.
//  Keeps a two-digit history: most recent key on the right digit, previous key on the left.
//  Time-multiplexes both digits onto one shared active-low 7-segment bus, with two anode enables.
//  Inserts dead-time between digits to prevent ghosting.
// PARAMETERS
//  REFRESH_DIV  16  log2 of cycles each digit is shown (SHOW phase = 2**REFRESH_DIV cycles)
//  DEAD_CYCLES  64  cycles both anodes are off between digits; 0 = no gap phase
// PORTS
//  clk        in   1  system clock; the only clock
//  reset      in   1  reset: synchronous, active-high
//  key_valid  in   1  debounced key-held level from scanner
//  key_value  in   4  hex code of held key; valid while key_valid=1
//  seg        out  7  {g,f,e,d,c,b,a}, active-low
//  an         out  2  active-low anodes; an[0]=right/recent, an[1]=left/older
//  new_key    out  1  one-cycle pulse when history updates
//  digit_rec  out  4  most recent key (debug)
//  digit_old  out  4  previous key (debug)
// BEHAVIOUR
//  Interface
//   - One clock; reset is synchronous and active-high.
//   - seg/an are combinational decodes of registered state/digits only; no input-to-output comb path.
//  Reset values
//   - digit_rec=0, digit_old=0, new_key=0, state=SHOW_R, cnt=0.
//   - an=2'b10; seg=7'b1000000 ('0').
//   - key_valid_q resets to 1, so a key held through reset is ignored until released.
//  Key acceptance
//   - Rising edge (key_valid & ~key_valid_q) in cycle k samples key_value.
//   - In cycle k+1: digit_old<=digit_rec, digit_rec<=sample, new_key=1 for exactly that cycle.
//   - Holding a key never repeats; release then re-press of the same key is accepted again.
//   - key_value is ignored when key_valid=0.
//  Mux FSM
//   - States: SHOW_R -> GAP_RL -> SHOW_L -> GAP_LR -> SHOW_R.
//   - Counter cnt (width max(REFRESH_DIV, clog2(DEAD_CYCLES+1))) clears on every transition.
//   - SHOW_x lasts 2**REFRESH_DIV cycles; GAP_x lasts DEAD_CYCLES cycles.
//   - If DEAD_CYCLES==0, SHOW_R<->SHOW_L directly; GAP states are never entered.
//   - an: SHOW_R=2'b10, SHOW_L=2'b01, GAP=2'b11.
//   - seg decodes digit of active anode; in GAP seg=7'b1111111.
//   - unreachable states -> SHOW_R next cycle.
//  Boundary conditions
//   - Key accepted mid-SHOW: seg changes the cycle after digit registers update; the FSM is not disturbed.
//   - Key edge coincident with a state transition: both take effect; no interaction.
//   - Reset mid-operation: all state returns to reset values on the next edge.
//   - Decode: 0=1000000, 1=1111001, A=0001000, F=0001110; full 0-F table in package.
// CONFIGURATION
//  KEY_HIST_BLANK_EN defined
//   - Per-digit valid flags, both 0 at reset; the flag sets when a digit first receives a key.
//   - Digit with flag 0 shows seg=7'b1111111 while its anode is on; anodes still cycle.
//   - First key: right digit valid, left still blank.
//  KEY_HIST_BLANK_EN undefined
//   - No flags; empty digits display '0'.
// STRUCTURE
//  Package key_display_pkg
//   - mux state enum
//   - SEG_BLANK constant
//   - 16-entry seg LUT constant
//   - anode pattern constants
//  Sub-module hex_to_sevenseg
//   - combinational 4-bit -> 7-bit active-low decoder
//   - one instance on the muxed digit
//  Edge detect, history registers, cnt and FSM
//   - all in top module, single always_ff on clk.
// TESTING (REFRESH_DIV=4, DEAD_CYCLES=2 unless noted)
//  1 Reset, no keys
//    - an sequence 10(16 cyc), 11(2), 01(16), 11(2), repeats
//    - seg=1000000 when an active; with KEY_HIST_BLANK_EN, seg=1111111 throughout
//  2 key_valid 0->1 with value 4'h1 held 100 cycles
//    - new_key single pulse one cycle after edge
//    - digit_rec=1, digit_old=0; no further updates
//  3 Then press 4'hA
//    - digit_rec=A, digit_old=1
//    - seg=0001000 while an=10; seg=1111001 while an=01
//  4 Press, release, press 4'hF
//    - two new_key pulses; digit_rec=F, digit_old=F
//  5 key_valid=1 held while reset asserted then released
//    - no update while held
//    - release + press 4'h3 -> digit_rec=3
//  6 DEAD_CYCLES=0
//    - an alternates 10/01 every 16 cycles, never 11
//    - key edge on transition cycle still updates digits

Source files
------------

// File: rtl/key_display_pkg.sv
// Shared types and constants for the two-digit key history display.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package key_display_pkg;

  typedef enum logic [1:0] {
    SHOW_R = 2'd0,
    GAP_RL = 2'd1,
    SHOW_L = 2'd2,
    GAP_LR = 2'd3
  } mux_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the glyph for hex digit n (highest index listed first).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [1:0] AN_RIGHT = 2'b10;
  localparam logic [1:0] AN_LEFT  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_sevenseg
  import key_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule

// File: rtl/key_history_display.sv
// Two-digit key history multiplexed onto one active-low 7-segment bus with dead-time.
// Optional macro KEY_HIST_BLANK_EN: digits that never received a key stay blank.
//
//   state  | meaning
//   SHOW_R | right anode on, most recent key shown
//   GAP_RL | both anodes off, moving right -> left
//   SHOW_L | left anode on, previous key shown
//   GAP_LR | both anodes off, moving left -> right
module key_history_display
  import key_display_pkg::*;
#(
  parameter int REFRESH_DIV = 16,
  parameter int DEAD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       new_key,
  output logic [3:0] digit_rec,
  output logic [3:0] digit_old
);

  localparam int GAP_W     = $clog2(DEAD_CYCLES + 1);
  localparam int CNT_W_RAW = (REFRESH_DIV > GAP_W) ? REFRESH_DIV : GAP_W;
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam bit HAS_GAP   = (DEAD_CYCLES > 0);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'((2 ** REFRESH_DIV) - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(HAS_GAP ? DEAD_CYCLES - 1 : 0);

  mux_state_e       state;
  mux_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic             key_valid_q;
  logic             key_edge;
  logic             valid_rec;
  logic             valid_old;
  logic             digit_lit;
  logic [3:0]       digit_sel;
  logic [6:0]       seg_dec;

  assign key_edge = key_valid & ~key_valid_q;

  always_comb begin
    state_next = state;
    case (state)
      SHOW_R:  if (cnt == SHOW_LAST) state_next = HAS_GAP ? GAP_RL : SHOW_L;
      GAP_RL:  if (cnt == GAP_LAST)  state_next = SHOW_L;
      SHOW_L:  if (cnt == SHOW_LAST) state_next = HAS_GAP ? GAP_LR : SHOW_R;
      GAP_LR:  if (cnt == GAP_LAST)  state_next = SHOW_R;
      default: state_next = SHOW_R;
    endcase
  end

  // key_valid_q resets high so a key held through reset needs a release first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SHOW_R;
      cnt         <= '0;
      key_valid_q <= 1'b1;
      new_key     <= 1'b0;
      digit_rec   <= 4'h0;
      digit_old   <= 4'h0;
      valid_rec   <= 1'b0;
      valid_old   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= (state_next != state) ? '0 : cnt + 1'b1;
      key_valid_q <= key_valid;
      new_key     <= key_edge;
      if (key_edge) begin
        digit_rec <= key_value;
        digit_old <= digit_rec;
        valid_rec <= 1'b1;
        valid_old <= valid_rec;
      end
    end
  end

  always_comb begin
    an        = AN_OFF;
    digit_sel = digit_rec;
    digit_lit = 1'b0;
    case (state)
      SHOW_R: begin
        an        = AN_RIGHT;
        digit_sel = digit_rec;
`ifdef KEY_HIST_BLANK_EN
        digit_lit = valid_rec;
`else
        digit_lit = 1'b1;
`endif
      end
      SHOW_L: begin
        an        = AN_LEFT;
        digit_sel = digit_old;
`ifdef KEY_HIST_BLANK_EN
        digit_lit = valid_old;
`else
        digit_lit = 1'b1;
`endif
      end
      default: begin
        an        = AN_OFF;
        digit_lit = 1'b0;
      end
    endcase
  end

  hex_to_sevenseg u_decode (
    .digit (digit_sel),
    .seg   (seg_dec)
  );

  assign seg = digit_lit ? seg_dec : SEG_BLANK;

endmodule
